// File: rtl/tbuf_bus_arbiter_pkg.sv
// Shared definitions for the round-robin tristate bus arbiter family:
// FSM state encoding, turnaround counter width and a constant clog2 helper.
package tbuf_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_e;

  localparam int TURN_CW = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/tbuf_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping modulo N. Reusable by any arbiter needing a rotating priority.
module rr_pick
  import tbuf_bus_arbiter_pkg::*;
#(
  parameter int N   = 8,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] winner,
  output logic           any
);

  int             idx;
  logic [IDW-1:0] w_sel;

  // Scan from the farthest offset back to ptr so the nearest requester is the last write.
  // NOTE: every variable of an always_comb gets a value before any branch, so no latch can be inferred.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    w_sel  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      w_sel = IDW'(idx);
      if (req[w_sel]) begin
        winner = w_sel;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tbuf_bus_arbiter.sv
// N-channel shared tristate bus with round-robin ownership, programmable
// turnaround float between owners, optional hold limit and a registered tap.
module tbuf_bus_arbiter
  import tbuf_bus_arbiter_pkg::*;
#(
  parameter int N        = 8,
  parameter int W        = 1,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 0,
  parameter int IDW      = clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] di,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] owner_id,
  output tri   [W-1:0]   bus_o,
  output logic [W-1:0]   dout,
  output logic           dout_vld,
  output logic           busy
);

  localparam int HOLD_W    = (MAX_HOLD > 2) ? clog2(MAX_HOLD) : 1;
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam int TURN_LAST = (TURN_CYC > 0) ? TURN_CYC - 1 : 0;

  state_e             r_state, w_state_nxt;
  logic [N-1:0]       r_gnt, w_gnt_nxt;
  logic [IDW-1:0]     r_owner, w_owner_nxt;
  logic [IDW-1:0]     r_ptr, w_ptr_nxt;
  logic [IDW-1:0]     w_winner;
  logic [HOLD_W-1:0]  r_hold, w_hold_nxt;
  logic [TURN_CW-1:0] r_turn, w_turn_nxt;
  logic               w_any, w_grant;
  logic               w_release, w_others_req, w_rotate;
  logic [W-1:0]       w_bus_data;
  logic [W-1:0]       r_dout;
  logic               r_dout_vld;

  rr_pick #(.N(N), .IDW(IDW)) u_rr_pick (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .any    (w_any)
  );

  // r_gnt is the owner's one-hot while in OWN, so it doubles as the owner mask.
  assign w_release    = ~|(req & r_gnt);
  assign w_others_req = |(req & ~r_gnt);
  assign w_rotate     = (MAX_HOLD != 0) && (r_hold == HOLD_W'(HOLD_LAST)) && w_others_req;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    w_turn_nxt  = r_turn;
    w_grant     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_any) w_grant = 1'b1;
      end
      ST_OWN: begin
        if (w_release || w_rotate) begin
          if (!w_others_req) begin
            w_gnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else if (TURN_CYC == 0) begin
            w_grant = 1'b1;
          end else begin
            w_gnt_nxt   = '0;
            w_turn_nxt  = '0;
            w_state_nxt = ST_TURN;
          end
        end else if (r_hold != HOLD_W'(HOLD_LAST)) begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      ST_TURN: begin
        if (r_turn == TURN_CW'(TURN_LAST)) begin
          if (w_any) w_grant = 1'b1;
          else       w_state_nxt = ST_IDLE;
        end else begin
          w_turn_nxt = r_turn + 1'b1;
        end
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_grant) begin
      w_state_nxt           = ST_OWN;
      w_gnt_nxt             = '0;
      w_gnt_nxt[w_winner]   = 1'b1;
      w_owner_nxt           = w_winner;
      w_ptr_nxt             = (w_winner == IDW'(N - 1)) ? '0 : w_winner + 1'b1;
      w_hold_nxt            = '0;
    end
  end

  // Async reset clears r_gnt at once, which floats the bus without waiting for a clock.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_turn  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
      r_turn  <= w_turn_nxt;
    end
  end

  // One conditional driver per channel; r_gnt is one-hot so at most one is enabled.
  for (genvar i = 0; i < N; i++) begin : g_drv
    assign bus_o = r_gnt[i] ? di[i*W +: W] : {W{1'bz}};
  end

  // Same value the bus carries while granted, without reading the resolved net back.
  always_comb begin
    w_bus_data = '0;
    for (int i = 0; i < N; i++) begin
      if (r_gnt[i]) w_bus_data = w_bus_data | di[i*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
    end else begin
      r_dout_vld <= |r_gnt;
      if (|r_gnt) r_dout <= w_bus_data;
    end
  end

  assign gnt      = r_gnt;
  assign owner_id = r_owner;
  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Bench for tbuf_bus_arbiter: three configurations side by side, directed
// scenarios plus randomized traffic scored against an ownership-level model.
module tb_tbuf_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req_a  [3];
  logic [31:0] di_a   [3];
  logic [7:0]  gnt_a  [3];
  logic [2:0]  oid_a  [3];
  logic [3:0]  dout_a [3];
  logic        vld_a  [3];
  logic        busy_a [3];
  wire  [3:0]  bus0, bus1, bus2;
  logic [3:0]  bus_v  [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns the bus (-1 none), last owner, rotation start,
  // cycles already owned, remaining float cycles, registered tap.
  int         m_own  [3];
  int         m_last [3];
  int         m_ptr  [3];
  int         m_held [3];
  int         m_gap  [3];
  logic [3:0] m_dout [3];
  logic       m_vld  [3];

  always #5 clk = ~clk;

  assign bus_v[0] = bus0;
  assign bus_v[1] = bus1;
  assign bus_v[2] = bus2;

  tbuf_bus_arbiter #(.N(8), .W(4), .TURN_CYC(1), .MAX_HOLD(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_a[0]), .di(di_a[0]), .gnt(gnt_a[0]),
    .owner_id(oid_a[0]), .bus_o(bus0), .dout(dout_a[0]), .dout_vld(vld_a[0]), .busy(busy_a[0]));

  tbuf_bus_arbiter #(.N(8), .W(4), .TURN_CYC(1), .MAX_HOLD(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req_a[1]), .di(di_a[1]), .gnt(gnt_a[1]),
    .owner_id(oid_a[1]), .bus_o(bus1), .dout(dout_a[1]), .dout_vld(vld_a[1]), .busy(busy_a[1]));

  tbuf_bus_arbiter #(.N(8), .W(4), .TURN_CYC(0), .MAX_HOLD(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req_a[2]), .di(di_a[2]), .gnt(gnt_a[2]),
    .owner_id(oid_a[2]), .bus_o(bus2), .dout(dout_a[2]), .dout_vld(vld_a[2]), .busy(busy_a[2]));

  function automatic int turn_of(input int k);
    return (k == 2) ? 0 : 1;
  endfunction

  function automatic int hold_of(input int k);
    return (k == 1) ? 0 : 4;
  endfunction

  function automatic int pick(input logic [7:0] r, input int ptr);
    for (int s = 0; s < 8; s++) begin
      if (r[3'((ptr + s) % 8)]) return (ptr + s) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_own[k]  = -1;
      m_last[k] = 0;
      m_ptr[k]  = 0;
      m_held[k] = 0;
      m_gap[k]  = 0;
      m_dout[k] = 4'h0;
      m_vld[k]  = 1'b0;
    end
  endtask

  task automatic m_grant(input int k, input int w);
    m_own[k]  = w;
    m_last[k] = w;
    m_ptr[k]  = (w + 1) % 8;
    m_held[k] = 0;
  endtask

  task automatic model_step(input int k);
    logic [7:0] r;
    logic [7:0] mine;
    bit         others;
    r = req_a[k];
    m_vld[k] = (m_own[k] >= 0);
    if (m_own[k] >= 0) begin
      mine      = 8'(1 << m_own[k]);
      others    = (r & ~mine) != 8'h00;
      m_dout[k] = 4'(di_a[k] >> (4 * m_own[k]));
      if ((r & mine) == 8'h00 || (hold_of(k) != 0 && m_held[k] + 1 >= hold_of(k) && others)) begin
        if (!others)              m_own[k] = -1;
        else if (turn_of(k) == 0) m_grant(k, pick(r, m_ptr[k]));
        else begin
          m_own[k] = -1;
          m_gap[k] = turn_of(k);
        end
      end else begin
        m_held[k]++;
      end
    end else if (m_gap[k] > 0) begin
      m_gap[k]--;
      if (m_gap[k] == 0 && r != 8'h00) m_grant(k, pick(r, m_ptr[k]));
    end else if (r != 8'h00) begin
      m_grant(k, pick(r, m_ptr[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] d0;
    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      req_a[k] = 8'h00;
      di_a[k]  = $urandom;
    end
    req_a[0] = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (gnt_a[0] !== 8'h00 || busy_a[0] !== 1'b0 || vld_a[0] !== 1'b0 ||
          dout_a[0] !== 4'h0 || oid_a[0] !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_state: gnt=%h busy=%b vld=%b dout=%h oid=%0d, required 00 0 0 0 0",
                 gnt_a[0], busy_a[0], vld_a[0], dout_a[0], oid_a[0]);
      end
      n_tests++;
      if (!($isunknown(bus_v[0]) || bus_v[0] === 4'h0)) begin
        n_fail++;
        $display("FAIL reset_bus_float: bus=%h, required Z", bus_v[0]);
      end
    end
    rst_n = 1'b1;
    d0 = di_a[0][3:0];
    tick();
    n_tests++;
    if (gnt_a[0] !== 8'h01 || bus_v[0] !== d0 || vld_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL first_grant: gnt=%h bus=%h vld=%b, required 01 %h 0", gnt_a[0], bus_v[0], vld_a[0], d0);
    end
    tick();
    n_tests++;
    if (gnt_a[0] !== 8'h01 || vld_a[0] !== 1'b1 || dout_a[0] !== d0) begin
      n_fail++;
      $display("FAIL first_dout: gnt=%h vld=%b dout=%h, required 01 1 %h", gnt_a[0], vld_a[0], dout_a[0], d0);
    end
  endtask

  task automatic test_single();
    req_a[0] = 8'h00;
    tick();
    n_tests++;
    if (gnt_a[0] !== 8'h00 || busy_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL release_idle: gnt=%h busy=%b, required 00 0", gnt_a[0], busy_a[0]);
    end
    di_a[0][11:8] = 4'hA;
    req_a[0] = 8'h04;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (gnt_a[0] !== 8'h04 || bus_v[0] !== 4'hA || busy_a[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL single_own c%0d: gnt=%h bus=%h busy=%b, required 04 a 1", c, gnt_a[0], bus_v[0], busy_a[0]);
      end
      n_tests++;
      if (c > 0 && (vld_a[0] !== 1'b1 || dout_a[0] !== 4'hA)) begin
        n_fail++;
        $display("FAIL single_dout c%0d: vld=%b dout=%h, required 1 a", c, vld_a[0], dout_a[0]);
      end
    end
    req_a[0] = 8'h00;
    tick();
    n_tests++;
    if (gnt_a[0] !== 8'h00 || busy_a[0] !== 1'b0 || vld_a[0] !== 1'b1 || dout_a[0] !== 4'hA ||
        !($isunknown(bus_v[0]) || bus_v[0] === 4'h0)) begin
      n_fail++;
      $display("FAIL single_end: gnt=%h busy=%b vld=%b dout=%h bus=%h, required 00 0 1 a Z",
               gnt_a[0], busy_a[0], vld_a[0], dout_a[0], bus_v[0]);
    end
    tick();
    n_tests++;
    if (vld_a[0] !== 1'b0 || dout_a[0] !== 4'hA) begin
      n_fail++;
      $display("FAIL single_vld_drop: vld=%b dout=%h, required 0 a", vld_a[0], dout_a[0]);
    end
  endtask

  task automatic test_rotate();
    logic [7:0] exp;
    req_a[0] = 8'h06;
    for (int c = 0; c < 22; c++) begin
      tick();
      case (c % 10)
        0, 1, 2, 3: exp = 8'h02;
        5, 6, 7, 8: exp = 8'h04;
        default:    exp = 8'h00;
      endcase
      n_tests++;
      if (gnt_a[0] !== exp) begin
        n_fail++;
        $display("FAIL rotate c%0d: gnt=%h, required %h", c, gnt_a[0], exp);
      end
    end
  endtask

  task automatic test_hold_release();
    req_a[1] = 8'h06;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_tests++;
      if (gnt_a[1] !== 8'h02) begin
        n_fail++;
        $display("FAIL unlimited_hold c%0d: gnt=%h, required 02", c, gnt_a[1]);
      end
    end
    req_a[1] = 8'h04;
    tick();
    n_tests++;
    if (gnt_a[1] !== 8'h00 || busy_a[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_turn: gnt=%h busy=%b, required 00 1", gnt_a[1], busy_a[1]);
    end
    tick();
    n_tests++;
    if (gnt_a[1] !== 8'h04 || bus_v[1] !== di_a[1][11:8]) begin
      n_fail++;
      $display("FAIL hold_next: gnt=%h bus=%h, required 04 %h", gnt_a[1], bus_v[1], di_a[1][11:8]);
    end
  endtask

  task automatic test_zero_turn();
    req_a[2] = 8'h81;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if (gnt_a[2] !== 8'h01) begin
        n_fail++;
        $display("FAIL zt_first c%0d: gnt=%h, required 01", c, gnt_a[2]);
      end
    end
    req_a[2] = 8'h80;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if (gnt_a[2] !== 8'h80 || bus_v[2] !== di_a[2][31:28] || vld_a[2] !== 1'b1 || busy_a[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL zt_switch c%0d: gnt=%h bus=%h vld=%b busy=%b, required 80 %h 1 1",
                 c, gnt_a[2], bus_v[2], vld_a[2], busy_a[2], di_a[2][31:28]);
      end
    end
    n_tests++;
    if (dout_a[2] !== di_a[2][31:28]) begin
      n_fail++;
      $display("FAIL zt_dout: dout=%h, required %h", dout_a[2], di_a[2][31:28]);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_gnt;
    logic [3:0] exp_bus;
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(3, 0) == 0) req_a[k] = 8'($urandom & $urandom);
        di_a[k] = $urandom;
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        exp_gnt = (m_own[k] >= 0) ? 8'(1 << m_own[k]) : 8'h00;
        exp_bus = (m_own[k] >= 0) ? 4'(di_a[k] >> (4 * m_own[k])) : 4'h0;
        n_tests++;
        if (gnt_a[k] !== exp_gnt || oid_a[k] !== 3'(m_last[k]) ||
            busy_a[k] !== ((m_own[k] >= 0) || (m_gap[k] > 0))) begin
          n_fail++;
          $display("FAIL rand_ctrl u%0d c%0d: gnt=%h oid=%0d busy=%b, required %h %0d %b",
                   k, c, gnt_a[k], oid_a[k], busy_a[k], exp_gnt, m_last[k], (m_own[k] >= 0) || (m_gap[k] > 0));
        end
        n_tests++;
        if ((m_own[k] >= 0 && bus_v[k] !== exp_bus) ||
            (m_own[k] < 0 && !($isunknown(bus_v[k]) || bus_v[k] === 4'h0))) begin
          n_fail++;
          $display("FAIL rand_bus u%0d c%0d: bus=%h, required %h (Z when no owner)", k, c, bus_v[k], exp_bus);
        end
        n_tests++;
        if (vld_a[k] !== m_vld[k] || dout_a[k] !== m_dout[k]) begin
          n_fail++;
          $display("FAIL rand_dout u%0d c%0d: vld=%b dout=%h, required %b %h",
                   k, c, vld_a[k], dout_a[k], m_vld[k], m_dout[k]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    seen = 1'b0;
    req_a[0] = 8'h10;
    req_a[1] = 8'h00;
    req_a[2] = 8'h00;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (gnt_a[0] === 8'h10) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL arst_setup: gnt=%h, required 10 within 20 cycles", gnt_a[0]);
    end else begin
      rst_n = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if (gnt_a[0] !== 8'h00 || dout_a[0] !== 4'h0 || vld_a[0] !== 1'b0 ||
          busy_a[0] !== 1'b0 || oid_a[0] !== 3'd0 || !($isunknown(bus_v[0]) || bus_v[0] === 4'h0)) begin
        n_fail++;
        $display("FAIL arst_mid_own: gnt=%h dout=%h vld=%b busy=%b oid=%0d bus=%h, required 00 0 0 0 0 Z",
                 gnt_a[0], dout_a[0], vld_a[0], busy_a[0], oid_a[0], bus_v[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_hold_release();
    test_zero_turn();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
